// File: rtl/level_progression_ctrl_if.sv
// Signal bundle between the level progression controller and the game logic
// (score counter, hero position controllers, renderer).
interface level_progression_ctrl_if #(
    parameter int N_HERO  = 2,
    parameter int POS_W   = 12,
    parameter int SCORE_W = 24,
    parameter int LEVEL_W = 4
);
    logic                      enable;
    logic [SCORE_W-1:0]        score;
    logic [N_HERO*POS_W-1:0]   hero_x;
    logic [N_HERO*POS_W-1:0]   hero_y;
    logic [LEVEL_W-1:0]        level;
    logic [SCORE_W-1:0]        score_req;
    logic                      hero_rst;
    logic                      level_up;
    logic                      game_complete;
    logic                      busy;

    // No valid/ready handshake: inputs are level signals sampled every cycle,
    // level_up is a single-cycle strobe and all other outputs are held levels.
    modport master (
        output enable, score, hero_x, hero_y,
        input  level, score_req, hero_rst, level_up, game_complete, busy
    );

    modport slave (
        input  enable, score, hero_x, hero_y,
        output level, score_req, hero_rst, level_up, game_complete, busy
    );
endinterface

// File: rtl/level_progression_ctrl.sv
// Level progression: advances the level once every hero has dwelt in the goal
// window with enough score, then pulses hero reset and waits for them to leave.
module level_progression_ctrl #(
    parameter int N_HERO     = 2,
    parameter int POS_W      = 12,
    parameter int SCORE_W    = 24,
    parameter int LEVEL_W    = 4,
    parameter int MAX_LEVEL  = 10,
    parameter int WRAP       = 0,
    parameter int GOAL_X     = 482,
    parameter int GOAL_Y     = 108,
    parameter int GOAL_TOL   = 0,
    parameter int GOAL_DWELL = 1,
    parameter int SCORE_STEP = 1000,
    parameter int RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    level_progression_ctrl_if.slave  bus,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        ADVANCE = 2'd1,
        CLEAR   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DW_W = (GOAL_DWELL > 1) ? $clog2(GOAL_DWELL) : 1;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [POS_W-1:0]   X_LO       = POS_W'(GOAL_X - GOAL_TOL);
    localparam logic [POS_W-1:0]   X_HI       = POS_W'(GOAL_X + GOAL_TOL);
    localparam logic [POS_W-1:0]   Y_LO       = POS_W'(GOAL_Y - GOAL_TOL);
    localparam logic [POS_W-1:0]   Y_HI       = POS_W'(GOAL_Y + GOAL_TOL);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL - 1);
    localparam logic [DW_W-1:0]    DW_LAST    = DW_W'(GOAL_DWELL - 1);
    localparam logic [RC_W-1:0]    RC_LAST    = RC_W'(RST_CYCLES - 1);
    localparam logic [SCORE_W:0]   STEP_EXT   = (SCORE_W+1)'(SCORE_STEP);
    localparam logic [SCORE_W-1:0] STEP_INIT  = SCORE_W'(SCORE_STEP);

    state_t              state, state_n;
    logic [LEVEL_W-1:0]  level, level_n;
    logic [SCORE_W-1:0]  score_req, score_req_n;
    logic                hero_rst, hero_rst_n;
    logic                level_up, level_up_n;
    logic                game_complete, game_complete_n;
    logic                busy, busy_n;
    logic [DW_W-1:0]     dwell_cnt, dwell_cnt_n;
    logic [RC_W-1:0]     rst_cnt, rst_cnt_n;

    logic                all_in;
    logic                goal_met;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  req_sat;

    always_comb begin
        all_in = 1'b1;
        for (int i = 0; i < N_HERO; i++) begin
            if (!(bus.hero_x[i*POS_W +: POS_W] >= X_LO && bus.hero_x[i*POS_W +: POS_W] <= X_HI &&
                  bus.hero_y[i*POS_W +: POS_W] >= Y_LO && bus.hero_y[i*POS_W +: POS_W] <= Y_HI))
                all_in = 1'b0;
        end
    end

    assign goal_met  = all_in && (bus.score >= score_req) && bus.enable;
    // One extra bit catches the carry so the next requirement saturates.
    assign score_sum = {1'b0, bus.score} + STEP_EXT;
    assign req_sat   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= PLAY;
            level         <= '0;
            score_req     <= STEP_INIT;
            hero_rst      <= 1'b0;
            level_up      <= 1'b0;
            game_complete <= 1'b0;
            busy          <= 1'b0;
            dwell_cnt     <= '0;
            rst_cnt       <= '0;
        end else begin
            state         <= state_n;
            level         <= level_n;
            score_req     <= score_req_n;
            hero_rst      <= hero_rst_n;
            level_up      <= level_up_n;
            game_complete <= game_complete_n;
            busy          <= busy_n;
            dwell_cnt     <= dwell_cnt_n;
            rst_cnt       <= rst_cnt_n;
        end
    end

    always_comb begin
        state_n         = state;
        level_n         = level;
        score_req_n     = score_req;
        hero_rst_n      = hero_rst;
        level_up_n      = 1'b0;
        game_complete_n = game_complete;
        dwell_cnt_n     = dwell_cnt;
        rst_cnt_n       = rst_cnt;

        case (state)
            PLAY: begin
                if (!goal_met) begin
                    dwell_cnt_n = '0;
                end else if (dwell_cnt != DW_LAST) begin
                    dwell_cnt_n = dwell_cnt + 1'b1;
                end else begin
                    level_up_n  = 1'b1;
                    score_req_n = req_sat;
                    dwell_cnt_n = '0;
                    rst_cnt_n   = '0;
                    if (level < LAST_LEVEL) begin
                        level_n    = level + 1'b1;
                        hero_rst_n = 1'b1;
                        state_n    = ADVANCE;
                    end else if (WRAP != 0) begin
                        level_n    = '0;
                        hero_rst_n = 1'b1;
                        state_n    = ADVANCE;
                    end else begin
                        game_complete_n = 1'b1;
                        state_n         = DONE;
                    end
                end
            end
            // rst_cnt counts the cycles hero_rst has already been high.
            ADVANCE: begin
                if (rst_cnt == RC_LAST) begin
                    hero_rst_n = 1'b0;
                    rst_cnt_n  = '0;
                    state_n    = CLEAR;
                end else begin
                    rst_cnt_n = rst_cnt + 1'b1;
                end
            end
            CLEAR: begin
                dwell_cnt_n = '0;
                if (!all_in)
                    state_n = PLAY;
            end
            default: begin
            end
        endcase

        busy_n = (state_n != PLAY);
    end

    assign bus.level         = level;
    assign bus.score_req     = score_req;
    assign bus.hero_rst      = hero_rst;
    assign bus.level_up      = level_up;
    assign bus.game_complete = game_complete;
    assign bus.busy          = busy;
    assign state_dbg         = state;

endmodule

// File: tb/tb_level_progression_ctrl.sv
// Bench for level_progression_ctrl: three configurations (defaults, dwell/tolerance/
// last level, wrap) with an advance scoreboard per instance.
module tb_level_progression_ctrl;

    localparam int W = 28;
    localparam logic [1:0] S_PLAY = 2'd0, S_ADV = 2'd1, S_CLR = 2'd2, S_DONE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_checks = 0;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] exp_c[$];
    logic [W-1:0] w_a, w_b, w_c;
    logic [1:0]   st_a, st_b, st_c;

    always #5 clk = ~clk;

    level_progression_ctrl_if bus_a ();
    level_progression_ctrl_if bus_b ();
    level_progression_ctrl_if bus_c ();

    level_progression_ctrl u_a (.clk(clk), .rst(rst), .bus(bus_a), .state_dbg(st_a));
    level_progression_ctrl #(.GOAL_DWELL(3), .GOAL_TOL(2), .MAX_LEVEL(3), .WRAP(0))
        u_b (.clk(clk), .rst(rst), .bus(bus_b), .state_dbg(st_b));
    level_progression_ctrl #(.MAX_LEVEL(3), .WRAP(1))
        u_c (.clk(clk), .rst(rst), .bus(bus_c), .state_dbg(st_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] adv(input int lvl, input int req);
        return {4'(lvl), 24'(req)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic place(input int d, input int x0, input int y0, input int x1, input int y1);
        logic [23:0] xs, ys;
        xs = {12'(x1), 12'(x0)};
        ys = {12'(y1), 12'(y0)};
        case (d)
            0: begin bus_a.hero_x = xs; bus_a.hero_y = ys; end
            1: begin bus_b.hero_x = xs; bus_b.hero_y = ys; end
            default: begin bus_c.hero_x = xs; bus_c.hero_y = ys; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Scoreboard: every level_up must match the next queued {level, score_req}.
    always @(negedge clk) begin
        if (bus_a.level_up) begin
            if (exp_a.size() == 0) check("a_unexpected_level_up", 64'(bus_a.level_up), 64'd0);
            else begin
                w_a = exp_a.pop_front();
                check("a_advance", 64'({bus_a.level, bus_a.score_req}), 64'(w_a));
            end
        end
        if (bus_b.level_up) begin
            if (exp_b.size() == 0) check("b_unexpected_level_up", 64'(bus_b.level_up), 64'd0);
            else begin
                w_b = exp_b.pop_front();
                check("b_advance", 64'({bus_b.level, bus_b.score_req}), 64'(w_b));
            end
        end
        if (bus_c.level_up) begin
            if (exp_c.size() == 0) check("c_unexpected_level_up", 64'(bus_c.level_up), 64'd0);
            else begin
                w_c = exp_c.pop_front();
                check("c_advance", 64'({bus_c.level, bus_c.score_req}), 64'(w_c));
            end
        end
    end

    initial begin
        bus_a.enable = 1'b0; bus_a.score = '0;
        bus_b.enable = 1'b0; bus_b.score = '0;
        bus_c.enable = 1'b0; bus_c.score = '0;
        place(0, 0, 0, 0, 0);
        place(1, 0, 0, 0, 0);
        place(2, 0, 0, 0, 0);
        step(2);
        do_reset();

        // ---- defaults: reset state and first advance
        check("rst_level", 64'(bus_a.level), 64'd0);
        check("rst_score_req", 64'(bus_a.score_req), 64'd1000);
        check("rst_hero_rst", 64'(bus_a.hero_rst), 64'd0);
        check("rst_level_up", 64'(bus_a.level_up), 64'd0);
        check("rst_game_complete", 64'(bus_a.game_complete), 64'd0);
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_state", 64'(st_a), 64'(S_PLAY));

        place(0, 482, 108, 482, 108);
        bus_a.score = 24'd999;
        bus_a.enable = 1'b1;
        step(3);
        check("low_score_level", 64'(bus_a.level), 64'd0);
        check("low_score_state", 64'(st_a), 64'(S_PLAY));
        bus_a.score = 24'd1000;
        exp_a.push_back(adv(1, 2000));
        step(1);
        check("adv1_level_up", 64'(bus_a.level_up), 64'd1);
        check("adv1_level", 64'(bus_a.level), 64'd1);
        check("adv1_score_req", 64'(bus_a.score_req), 64'd2000);
        check("adv1_busy", 64'(bus_a.busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("adv1_hero_rst_high", 64'(bus_a.hero_rst), 64'd1);
            step(1);
            if (i < 3) check("adv1_level_up_once", 64'(bus_a.level_up), 64'd0);
        end
        check("adv1_hero_rst_drop", 64'(bus_a.hero_rst), 64'd0);
        check("adv1_clear", 64'(st_a), 64'(S_CLR));

        // ---- re-trigger block
        bus_a.score = 24'd5000;
        step(5);
        check("hold_clear_state", 64'(st_a), 64'(S_CLR));
        check("hold_clear_level", 64'(bus_a.level), 64'd1);
        check("hold_clear_busy", 64'(bus_a.busy), 64'd1);
        place(0, 0, 0, 482, 108);
        step(1);
        check("leave_play", 64'(st_a), 64'(S_PLAY));
        check("leave_busy", 64'(bus_a.busy), 64'd0);
        place(0, 482, 108, 482, 108);
        exp_a.push_back(adv(2, 6000));
        step(1);
        check("adv2_level_up", 64'(bus_a.level_up), 64'd1);
        check("adv2_score_req", 64'(bus_a.score_req), 64'd6000);
        step(4);
        check("adv2_clear", 64'(st_a), 64'(S_CLR));

        // ---- saturation, enable gating, reset mid-advance
        place(0, 0, 0, 482, 108);
        step(1);
        bus_a.score = 24'((1 << 24) - 100);
        place(0, 482, 108, 482, 108);
        exp_a.push_back(adv(3, 16777215));
        step(1);
        check("sat_score_req", 64'(bus_a.score_req), 64'd16777215);
        check("sat_level", 64'(bus_a.level), 64'd3);
        step(4);
        place(0, 0, 0, 482, 108);
        step(1);
        check("sat_back_play", 64'(st_a), 64'(S_PLAY));
        bus_a.enable = 1'b0;
        bus_a.score = 24'hFFFFFF;
        place(0, 482, 108, 482, 108);
        step(4);
        check("disabled_level", 64'(bus_a.level), 64'd3);
        check("disabled_state", 64'(st_a), 64'(S_PLAY));
        bus_a.enable = 1'b1;
        exp_a.push_back(adv(4, 16777215));
        step(1);
        check("adv4_level", 64'(bus_a.level), 64'd4);
        step(1);
        check("mid_adv_hero_rst", 64'(bus_a.hero_rst), 64'd1);
        rst = 1'b0;
        bus_a.enable = 1'b0;
        #1;
        check("async_hero_rst", 64'(bus_a.hero_rst), 64'd0);
        check("async_level", 64'(bus_a.level), 64'd0);
        check("async_score_req", 64'(bus_a.score_req), 64'd1000);
        check("async_state", 64'(st_a), 64'(S_PLAY));
        step(1);

        // ---- dwell = 3, tolerance = 2, last level without wrap
        do_reset();
        check("b_rst_score_req", 64'(bus_b.score_req), 64'd1000);
        place(1, 482, 108, 482, 108);
        bus_b.score = 24'd1000;
        bus_b.enable = 1'b1;
        step(2);
        check("dwell_2_cycles", 64'(bus_b.level_up), 64'd0);
        place(1, 482, 108, 0, 0);
        step(1);
        check("dwell_broken", 64'(bus_b.level_up), 64'd0);
        place(1, 482, 108, 482, 108);
        step(2);
        check("dwell_not_yet", 64'(bus_b.level_up), 64'd0);
        exp_b.push_back(adv(1, 2000));
        step(1);
        check("dwell_advance", 64'(bus_b.level_up), 64'd1);
        check("dwell_level", 64'(bus_b.level), 64'd1);
        step(4);
        check("b_clear", 64'(st_b), 64'(S_CLR));
        place(1, 482, 108, 479, 108);
        bus_b.score = 24'd3000;
        step(1);
        check("tol_out_play", 64'(st_b), 64'(S_PLAY));
        step(4);
        check("tol_out_level", 64'(bus_b.level), 64'd1);
        place(1, 484, 106, 480, 110);
        exp_b.push_back(adv(2, 4000));
        step(2);
        check("tol_in_wait", 64'(bus_b.level_up), 64'd0);
        step(1);
        check("tol_in_advance", 64'(bus_b.level_up), 64'd1);
        check("tol_in_score_req", 64'(bus_b.score_req), 64'd4000);
        step(4);
        place(1, 482, 108, 0, 0);
        step(1);
        place(1, 482, 108, 482, 108);
        bus_b.score = 24'd4000;
        exp_b.push_back(adv(2, 5000));
        step(3);
        check("last_level_up", 64'(bus_b.level_up), 64'd1);
        check("last_state", 64'(st_b), 64'(S_DONE));
        check("last_complete", 64'(bus_b.game_complete), 64'd1);
        check("last_hero_rst", 64'(bus_b.hero_rst), 64'd0);
        check("last_level", 64'(bus_b.level), 64'd2);
        place(1, 0, 0, 0, 0);
        step(2);
        place(1, 482, 108, 482, 108);
        bus_b.score = 24'd9000;
        step(5);
        check("done_state", 64'(st_b), 64'(S_DONE));
        check("done_level", 64'(bus_b.level), 64'd2);
        check("done_hero_rst", 64'(bus_b.hero_rst), 64'd0);
        check("done_busy", 64'(bus_b.busy), 64'd1);
        bus_b.enable = 1'b0;

        // ---- wrap after the last level
        do_reset();
        bus_c.enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            place(2, 482, 108, 482, 108);
            bus_c.score = 24'((k + 1) * 1000);
            exp_c.push_back(adv((k + 1) % 3, (k + 2) * 1000));
            step(1);
            check("wrap_level_up", 64'(bus_c.level_up), 64'd1);
            check("wrap_level", 64'(bus_c.level), 64'((k + 1) % 3));
            check("wrap_hero_rst", 64'(bus_c.hero_rst), 64'd1);
            check("wrap_complete", 64'(bus_c.game_complete), 64'd0);
            step(4);
            check("wrap_clear", 64'(st_c), 64'(S_CLR));
            place(2, 0, 0, 482, 108);
            step(1);
        end
        bus_c.enable = 1'b0;
        step(2);

        check("drain_a", 64'(exp_a.size()), 64'd0);
        check("drain_b", 64'(exp_b.size()), 64'd0);
        check("drain_c", 64'(exp_c.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/level_progression_ctrl.md
Name: level_progression_ctrl

Overview:
Parametrised successor to the level manager. Tracks game level and the per-level score requirement. It detects that all heroes are inside a goal window for a programmable dwell time with enough score, then advances the level. It generates a multi-cycle hero reset and a one-cycle level-up pulse, and blocks re-triggering until the heroes leave the goal. It sits between the score counter, hero position controllers and the renderer/level-map logic.

Parameters:
N_HERO, 2, number of heroes that must all be in the goal window (1..4)
POS_W, 12, width of each hero coordinate
SCORE_W, 24, score width
LEVEL_W, 4, level register width
MAX_LEVEL, 10, number of levels; valid levels 0..MAX_LEVEL-1 (MAX_LEVEL <= 2**LEVEL_W)
WRAP, 0, 1: wrap to level 0 after the last level; 0: stop in DONE
GOAL_X, 482, goal window centre x
GOAL_Y, 108, goal window centre y
GOAL_TOL, 0, half-width of the window in pixels; GOAL_X, GOAL_Y must be >= GOAL_TOL
GOAL_DWELL, 1, consecutive in-window cycles required (>=1)
SCORE_STEP, 1000, score increment required per level
RST_CYCLES, 4, hero_rst pulse length in cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active low (asserted when 0)
enable  in  1  game running; when low, no new advance can start
score  in  SCORE_W  current score
hero_x  in  N_HERO*POS_W  packed x positions, hero i at [i*POS_W +: POS_W]
hero_y  in  N_HERO*POS_W  packed y positions, same packing
level  out  LEVEL_W  current level
score_req  out  SCORE_W  score needed to clear the current level
hero_rst  out  1  hero position reset, high for RST_CYCLES cycles
level_up  out  1  one-cycle pulse on each advance
game_complete  out  1  high in DONE
busy  out  1  high in any state other than PLAY

Behaviour:
- Reset (rst=0, async): state=PLAY, level=0, score_req=SCORE_STEP, hero_rst=0, level_up=0, game_complete=0, dwell and pulse counters 0. All outputs are registered.
- in_win[i] = GOAL_X-GOAL_TOL <= x_i <= GOAL_X+GOAL_TOL, and the same test on y. Comparisons are unsigned and inclusive.
- goal_met = AND of all in_win[i], AND (score >= score_req), AND enable.
- PLAY:
  - dwell_cnt increments while goal_met; it clears to 0 on any cycle with goal_met=0.
  - When goal_met and dwell_cnt == GOAL_DWELL-1: advance at the next edge. With GOAL_DWELL=1, the advance happens at the edge after the first qualifying cycle.
- Advance edge:
  - level_up <= 1 for exactly one cycle.
  - score_req <= score + SCORE_STEP, saturating at 2**SCORE_W-1.
  - dwell_cnt <= 0.
  - If level < MAX_LEVEL-1: level <= level+1, hero_rst <= 1, go to ADVANCE.
  - If level == MAX_LEVEL-1 and WRAP=1: level <= 0, hero_rst <= 1, go to ADVANCE.
  - If level == MAX_LEVEL-1 and WRAP=0: level unchanged, hero_rst stays 0, game_complete <= 1, go to DONE.
- ADVANCE:
  - hero_rst is held high for exactly RST_CYCLES cycles, counted from the advance edge, then drops.
  - The state moves to CLEAR on the same edge that hero_rst drops.
  - enable is ignored in this state.
- CLEAR:
  - Return to PLAY on the first cycle in which at least one hero is not in_win.
  - While every hero remains in the window, stay in CLEAR. This prevents a double advance.
  - dwell_cnt is held at 0 here.
- DONE: terminal state. Outputs are frozen, game_complete=1. Only reset exits.
- busy = (state != PLAY).
- A score decrease after an advance has no effect on the advance. score_req is only updated on an advance edge.
- Reset mid-ADVANCE: hero_rst drops asynchronously and the state returns to PLAY at level 0.

Test Plan:
1. Defaults. Reset, then score=999 with both heroes at (482,108) -> no advance. Set score=1000 -> level_up pulses the edge after; level=1, score_req=2000, hero_rst high exactly 4 cycles, busy high.
2. Dwell (GOAL_DWELL=3). Both heroes in window for 2 cycles, one leaves, then both in for 3 cycles -> exactly one advance, at the edge after the 3rd qualifying cycle.
3. Tolerance (GOAL_TOL=2). Hero0 at (484,106), hero1 at (480,110) -> advance. Move hero1 to (479,108) -> no advance.
4. Re-trigger block. Heroes held at the goal after hero_rst ends with score=5000 -> state stays CLEAR and level does not change. Move one hero to (0,0) -> PLAY, then return to the goal -> second advance, score_req=6000.
5. Last level, MAX_LEVEL=3. Advance from level 2 with WRAP=0 -> DONE, game_complete=1, level=2, no hero_rst, further goals ignored. With WRAP=1 -> level=0 and hero_rst pulses.
6. Edge cases. score=2**24-100 at advance -> score_req=16777215 (saturated). enable=0 at the goal -> no advance. Assert rst low in the 2nd hero_rst cycle -> hero_rst=0, level=0, score_req=1000 immediately.
